// File: rtl/reg_scoreboard.sv
// Register-dependency scoreboard: per-register pending-write counters driving the decode stall.
// Optional macro REG_SCB_RET_BYPASS_EN lets a same-cycle retire of the last pending write unblock a source read.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic             iss_wr_en,
  input  logic [4:0]       iss_rd,
  input  logic [4:0]       iss_rs,
  input  logic [4:0]       iss_rt,
  input  logic             ret_valid,
  input  logic [4:0]       ret_rd,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic [CNT_W+4:0] inflight,
  output logic             err_underflow
);

  localparam int INF_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;

  logic haz_rs, haz_rt, haz_waw;
  logic acc, rec, rel, same_reg, underflow;

  always_comb begin
    haz_rs = (iss_rs != 5'd0) && (cnt_q[iss_rs] != '0);
    haz_rt = (iss_rt != 5'd0) && (cnt_q[iss_rt] != '0);
`ifdef REG_SCB_RET_BYPASS_EN
    // Write-first register file: the retiring value is visible to decode this cycle.
    if (ret_valid && (ret_rd == iss_rs) && (cnt_q[iss_rs] == CNT_W'(1))) haz_rs = 1'b0;
    if (ret_valid && (ret_rd == iss_rt) && (cnt_q[iss_rt] == CNT_W'(1))) haz_rt = 1'b0;
`endif
    haz_waw = iss_wr_en && (iss_rd != 5'd0) && (cnt_q[iss_rd] == CNT_MAX);
  end

  assign stall     = iss_valid && (haz_rs || haz_rt || haz_waw);
  assign acc       = iss_valid && !stall;
  assign rec       = acc && iss_wr_en && (iss_rd != 5'd0);
  assign rel       = ret_valid && (ret_rd != 5'd0);
  assign same_reg  = rec && rel && (iss_rd == ret_rd);
  assign underflow = rel && !same_reg && (cnt_q[ret_rd] == '0);

  always_comb begin
    cnt_d      = cnt_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    if (flush) begin
      for (int i = 0; i < 32; i++) cnt_d[i] = '0;
      inflight_d = '0;
      err_d      = 1'b0;
    end else if (!same_reg) begin
      if (rec) cnt_d[iss_rd] = cnt_q[iss_rd] + CNT_W'(1);
      if (rel) begin
        if (underflow) err_d = 1'b1;
        else           cnt_d[ret_rd] = cnt_q[ret_rd] - CNT_W'(1);
      end
      inflight_d = inflight_q + INF_W'(rec) - INF_W'(rel && !underflow);
    end
  end

  // Entry 0 is held at zero so $zero never creates a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q[0] <= '0;
      for (int i = 1; i < 32; i++) cnt_q[i] <= cnt_d[i];
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign busy          = (inflight_q != '0);
  assign inflight      = inflight_q;
  assign err_underflow = err_q;

endmodule
